// File: rtl/processor_pkg.sv
// Shared definitions for the memory stage: EX/MEM field widths, flag bit
// positions, the memory-stage FSM state type and a flags-to-word helper.
package processor_pkg;

  localparam int unsigned ADDR_W_DEF = 11;  // default data-memory word-address width
  localparam int unsigned DATA_W     = 32;  // EX/MEM Data / Address width
  localparam int unsigned WORD_W     = 16;  // data-memory word width
  localparam int unsigned REG_ADDR_W = 3;   // WB_Address width
  localparam int unsigned FLAGS_W    = 3;   // {NF, CF, ZF}

  localparam int unsigned NF = 2;
  localparam int unsigned CF = 1;
  localparam int unsigned ZF = 0;

  typedef enum logic {
    StIdle,
    StSecond
  } mem_state_e;

  // Which 2-word PC operation is in flight while in StSecond.
  typedef enum logic {
    OpPush,
    OpPop
  } pc_op_e;

  // Flags are stored zero-extended into one memory word.
  function automatic logic [WORD_W-1:0] flags_word(input logic [FLAGS_W-1:0] f);
    return {13'b0, f[NF], f[CF], f[ZF]};
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// EX/MEM -> memory stage bundle plus the memory stage's MEM/WB and feedback
// outputs.
//   master: upstream/pipeline side (drives EX/MEM fields, observes results)
//   slave : memory stage (consumes EX/MEM fields, drives results)
interface memory_stage_if;
  import processor_pkg::*;

  // EX/MEM fields
  logic [DATA_W-1:0]     Data;
  logic [DATA_W-1:0]     Address;
  logic                  MR;
  logic                  MW;
  logic                  WB;
  logic [REG_ADDR_W-1:0] WB_Address;
  logic                  JWSP;
  logic                  Stack_PC;
  logic                  Stack_Flags;
  logic [FLAGS_W-1:0]    Final_Flags;

  // Hazard control back to the pipeline
  logic                  Stall;
  logic                  Extra_SP_Step;

  // MEM/WB fields and feedback to fetch/execute
  logic                  WB_Out;
  logic [REG_ADDR_W-1:0] WB_Address_Out;
  logic [WORD_W-1:0]     WB_Data;
  logic [DATA_W-1:0]     PC_From_Memory;
  logic                  PC_Load;
  logic [FLAGS_W-1:0]    Flags_From_Memory;
  logic                  Mem_Fault;

  modport master (
    output Data, Address, MR, MW, WB, WB_Address, JWSP, Stack_PC, Stack_Flags, Final_Flags,
    input  Stall, Extra_SP_Step, WB_Out, WB_Address_Out, WB_Data, PC_From_Memory, PC_Load,
           Flags_From_Memory, Mem_Fault
  );

  modport slave (
    input  Data, Address, MR, MW, WB, WB_Address, JWSP, Stack_PC, Stack_Flags, Final_Flags,
    output Stall, Extra_SP_Step, WB_Out, WB_Address_Out, WB_Data, PC_From_Memory, PC_Load,
           Flags_From_Memory, Mem_Fault
  );

endinterface

// File: rtl/data_memory.sv
// Single-port data memory: asynchronous read, synchronous write, no reset.
//   clk_i   : write clock
//   we_i    : write enable
//   addr_i  : word address shared by read and write
//   wdata_i : write data
//   rdata_o : combinational read of addr_i
module data_memory #(
  parameter int unsigned AddrW = 11,
  parameter int unsigned DataW = 16
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_stage.sv
// Memory stage: performs data-memory loads/stores and flag/PC stack accesses
// for the EX/MEM instruction and registers the MEM/WB fields.
//   Clk   : clock
//   Rst_N : asynchronous active-low reset
//   bus   : memory_stage_if.slave -- EX/MEM fields in; Stall/Extra_SP_Step
//           (combinational) and registered WB_Out, WB_Address_Out, WB_Data,
//           PC_From_Memory, PC_Load, Flags_From_Memory, Mem_Fault out.
// A 32-bit PC push/pop takes two word accesses: the first in StIdle (with
// Stall raised so upstream holds), the second in StSecond from latched state.
// Stack layout: high PC word at A, low word at A-1.
module memory_stage
  import processor_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic           Clk,
  input  logic           Rst_N,
  memory_stage_if.slave  bus
);

  mem_state_e            state_q, state_d;
  pc_op_e                op_q, op_d;
  logic [ADDR_W-1:0]     hold_addr_q, hold_addr_d;
  logic [WORD_W-1:0]     hold_data_q, hold_data_d;

  logic                  wb_out_q, wb_out_d;
  logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [WORD_W-1:0]     wb_data_q, wb_data_d;
  logic [DATA_W-1:0]     pc_q, pc_d;
  logic                  pc_load_q, pc_load_d;
  logic [FLAGS_W-1:0]    flags_q, flags_d;
  logic                  fault_q, fault_d;

  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [WORD_W-1:0]     mem_wdata;
  logic [WORD_W-1:0]     mem_rdata;

  logic [ADDR_W-1:0]     addr_w;
  logic                  addr_bad;
  logic                  access;
  logic                  idle_go;
  logic                  fault;
  logic                  ok;
  logic                  pc_op;

  // JWSP only distinguishes a call from a plain push upstream; the memory
  // access is identical here.
  logic                  unused_jwsp;
  assign unused_jwsp = bus.JWSP;

  assign addr_w   = bus.Address[ADDR_W-1:0];
  assign addr_bad = |bus.Address[DATA_W-1:ADDR_W];
  assign access   = bus.MR | bus.MW;
  // Inputs are only acted on in StIdle and never while reset is held.
  assign idle_go  = Rst_N && (state_q == StIdle);
  assign fault    = idle_go & access & ((bus.MR & bus.MW) | addr_bad);
  assign ok       = idle_go & access & ~fault;
  assign pc_op    = ok & bus.Stack_PC;

  assign bus.Stall         = pc_op;
  assign bus.Extra_SP_Step = pc_op;

  // Memory port steering
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_w;
    mem_wdata = bus.Data[WORD_W-1:0];
    if (state_q == StSecond) begin
      mem_addr  = hold_addr_q;
      mem_wdata = hold_data_q;
      mem_we    = (op_q == OpPush);
    end else if (ok && bus.MW) begin
      mem_we = 1'b1;
      if (bus.Stack_PC) begin
        mem_wdata = bus.Data[DATA_W-1:WORD_W];
      end else if (bus.Stack_Flags) begin
        mem_wdata = flags_word(bus.Final_Flags);
      end
    end
  end

  data_memory #(
    .AddrW (ADDR_W),
    .DataW (WORD_W)
  ) u_mem (
    .clk_i   (Clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  // Next state
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    wb_out_d    = wb_out_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    pc_d        = pc_q;
    pc_load_d   = 1'b0;
    flags_d     = flags_q;
    fault_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fault) begin
          // Illegal access: suppress write-back, leave everything else alone.
          wb_out_d = 1'b0;
          fault_d  = 1'b1;
        end else begin
          wb_out_d  = bus.WB;
          wb_addr_d = bus.WB_Address;
          if (pc_op) begin
            wb_out_d = 1'b0;
            state_d  = StSecond;
            if (bus.MW) begin
              op_d        = OpPush;
              hold_addr_d = addr_w - ADDR_W'(1);
              hold_data_d = bus.Data[WORD_W-1:0];
            end else begin
              op_d        = OpPop;
              hold_addr_d = addr_w + ADDR_W'(1);
              hold_data_d = mem_rdata;
            end
          end else if (bus.MR) begin
            wb_data_d = mem_rdata;
            if (bus.Stack_Flags) begin
              flags_d = mem_rdata[FLAGS_W-1:0];
            end
          end else begin
            // Stores and non-memory ops forward the low data word.
            wb_data_d = bus.Data[WORD_W-1:0];
          end
        end
      end
      StSecond: begin
        state_d   = StIdle;
        wb_out_d  = bus.WB;
        wb_addr_d = bus.WB_Address;
        if (op_q == OpPop) begin
          pc_d      = {mem_rdata, hold_data_q};
          pc_load_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q     <= StIdle;
      op_q        <= OpPush;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      wb_out_q    <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      pc_q        <= '0;
      pc_load_q   <= 1'b0;
      flags_q     <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      wb_out_q    <= wb_out_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      pc_q        <= pc_d;
      pc_load_q   <= pc_load_d;
      flags_q     <= flags_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.WB_Out            = wb_out_q;
  assign bus.WB_Address_Out    = wb_addr_q;
  assign bus.WB_Data           = wb_data_q;
  assign bus.PC_From_Memory    = pc_q;
  assign bus.PC_Load           = pc_load_q;
  assign bus.Flags_From_Memory = flags_q;
  assign bus.Mem_Fault         = fault_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: the stimulus process queues expected
// results tagged with the cycle they must appear in; a monitor pops and
// compares them on the falling edge.
module tb_memory_stage;
  import processor_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_stage_if bus ();

  memory_stage #(
    .ADDR_W (11)
  ) dut (
    .Clk   (clk),
    .Rst_N (rst_n),
    .bus   (bus)
  );

  typedef enum {KWb, KWbOff, KPc, KPcOff, KFlags, KFault, KFaultOff} kind_e;

  typedef struct {
    int          cyc;
    string       name;
    kind_e       kind;
    logic        wbo;
    logic [2:0]  wba;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Queue an expectation lat cycles after the op issued next.
  function automatic void expect_at(input int lat, input string nm, input kind_e k,
                                    input logic wbo, input logic [2:0] wba,
                                    input logic [31:0] val);
    exp_t e;
    e.cyc  = cyc + 1 + lat;
    e.name = nm;
    e.kind = k;
    e.wbo  = wbo;
    e.wba  = wba;
    e.val  = val;
    sb.push_back(e);
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) chk({e.name, " late"}, cyc, e.cyc);
        case (e.kind)
          KWb: begin
            chk({e.name, " WB_Out"}, bus.WB_Out, e.wbo);
            chk({e.name, " WB_Address_Out"}, bus.WB_Address_Out, e.wba);
            chk({e.name, " WB_Data"}, bus.WB_Data, e.val);
          end
          KWbOff:    chk({e.name, " WB_Out"}, bus.WB_Out, 0);
          KPc: begin
            chk({e.name, " PC_Load"}, bus.PC_Load, 1);
            chk({e.name, " PC_From_Memory"}, bus.PC_From_Memory, e.val);
          end
          KPcOff:    chk({e.name, " PC_Load"}, bus.PC_Load, 0);
          KFlags:    chk({e.name, " Flags_From_Memory"}, bus.Flags_From_Memory, e.val);
          KFault: begin
            chk({e.name, " Mem_Fault"}, bus.Mem_Fault, 1);
            chk({e.name, " WB_Out"}, bus.WB_Out, 0);
          end
          KFaultOff: chk({e.name, " Mem_Fault"}, bus.Mem_Fault, 0);
          default:   chk({e.name, " kind"}, 0, 1);
        endcase
      end
    end
  end

  task automatic drive(input logic mr, input logic mw, input logic wb, input logic [2:0] wba,
                       input logic spc, input logic sflg, input logic [2:0] ff,
                       input logic [31:0] data, input logic [31:0] addr);
    bus.MR          = mr;
    bus.MW          = mw;
    bus.WB          = wb;
    bus.WB_Address  = wba;
    bus.Stack_PC    = spc;
    bus.Stack_Flags = sflg;
    bus.JWSP        = spc & mw;
    bus.Final_Flags = ff;
    bus.Data        = data;
    bus.Address     = addr;
  endtask

  // Present one EX/MEM op; for 2-word ops hold it through the StSecond cycle.
  task automatic op(input string nm, input logic mr, input logic mw, input logic wb,
                    input logic [2:0] wba, input logic spc, input logic sflg,
                    input logic [2:0] ff, input logic [31:0] data, input logic [31:0] addr,
                    input logic stall);
    @(posedge clk);
    #1;
    drive(mr, mw, wb, wba, spc, sflg, ff, data, addr);
    @(negedge clk);
    chk({nm, " Stall"}, bus.Stall, stall);
    chk({nm, " Extra_SP_Step"}, bus.Extra_SP_Step, stall);
    if (stall) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk({nm, " Stall second"}, bus.Stall, 0);
    end
  endtask

  initial begin
    // Reset with unknown inputs
    bus.MR = 'x; bus.MW = 'x; bus.WB = 'x; bus.WB_Address = 'x; bus.JWSP = 'x;
    bus.Stack_PC = 'x; bus.Stack_Flags = 'x; bus.Final_Flags = 'x;
    bus.Data = 'x; bus.Address = 'x;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst WB_Out", bus.WB_Out, 0);
    chk("rst WB_Address_Out", bus.WB_Address_Out, 0);
    chk("rst WB_Data", bus.WB_Data, 0);
    chk("rst PC_From_Memory", bus.PC_From_Memory, 0);
    chk("rst PC_Load", bus.PC_Load, 0);
    chk("rst Flags", bus.Flags_From_Memory, 0);
    chk("rst Mem_Fault", bus.Mem_Fault, 0);
    chk("rst Stall", bus.Stall, 0);
    chk("rst Extra_SP_Step", bus.Extra_SP_Step, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Store then load
    expect_at(1, "st5", KWb, 0, 0, 32'hBEEF);
    op("st5", 0, 1, 0, 0, 0, 0, 0, 32'h0000_BEEF, 5, 0);
    expect_at(1, "ld5", KWb, 1, 3, 32'hBEEF);
    op("ld5", 1, 0, 1, 3, 0, 0, 0, 0, 5, 0);
    expect_at(1, "st0", KWb, 0, 0, 32'h4242);
    op("st0", 0, 1, 0, 0, 0, 0, 0, 32'h4242, 0, 0);
    expect_at(1, "st19", KWb, 0, 0, 32'h1111);
    op("st19", 0, 1, 0, 0, 0, 0, 0, 32'h1111, 19, 0);

    // PC push at top of memory, then back-to-back pop
    expect_at(1, "push", KWbOff, 0, 0, 0);
    expect_at(1, "push", KPcOff, 0, 0, 0);
    expect_at(2, "push second", KPcOff, 0, 0, 0);
    op("push", 0, 1, 0, 0, 1, 0, 0, 32'h1234_5678, 32'h7FF, 1);
    expect_at(1, "pop", KPcOff, 0, 0, 0);
    expect_at(2, "pop", KPc, 0, 0, 32'h1234_5678);
    expect_at(3, "pop after", KPcOff, 0, 0, 0);
    op("pop", 1, 0, 0, 0, 1, 0, 0, 0, 32'h7FE, 1);
    expect_at(1, "ld7FF", KWb, 1, 1, 32'h1234);
    op("ld7FF", 1, 0, 1, 1, 0, 0, 0, 0, 32'h7FF, 0);
    expect_at(1, "ld7FE", KWb, 1, 2, 32'h5678);
    op("ld7FE", 1, 0, 1, 2, 0, 0, 0, 0, 32'h7FE, 0);

    // Flags push / pop
    expect_at(1, "pushf", KWbOff, 0, 0, 0);
    op("pushf", 0, 1, 0, 0, 0, 1, 3'b101, 32'hFFFF, 10, 0);
    expect_at(1, "popf", KFlags, 0, 0, 32'h5);
    op("popf", 1, 0, 0, 0, 0, 1, 0, 0, 10, 0);
    expect_at(1, "ld10", KWb, 1, 4, 32'h0005);
    op("ld10", 1, 0, 1, 4, 0, 0, 0, 0, 10, 0);

    // Faults
    expect_at(1, "fault rw", KFault, 0, 0, 0);
    expect_at(2, "fault rw after", KFaultOff, 0, 0, 0);
    op("fault rw", 1, 1, 1, 5, 0, 0, 0, 32'h7777, 5, 0);
    expect_at(1, "ld5 again", KWb, 1, 3, 32'hBEEF);
    op("ld5 again", 1, 0, 1, 3, 0, 0, 0, 0, 5, 0);
    expect_at(1, "fault addr", KFault, 0, 0, 0);
    expect_at(2, "fault addr after", KFaultOff, 0, 0, 0);
    op("fault addr", 0, 1, 1, 5, 0, 0, 0, 32'h9999, 32'h0001_0000, 0);
    expect_at(1, "ld0", KWb, 1, 6, 32'h4242);
    op("ld0", 1, 0, 1, 6, 0, 0, 0, 0, 0, 0);
    expect_at(1, "fault pc", KFault, 0, 0, 0);
    op("fault pc", 0, 1, 0, 0, 1, 0, 0, 32'hAAAA_BBBB, 32'h0000_0800, 0);

    // Reset while in the second cycle of a push
    @(posedge clk);
    #1;
    drive(0, 1, 0, 0, 1, 0, 0, 32'hCAFE_D00D, 20);
    @(negedge clk);
    chk("rstmid Stall", bus.Stall, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid Stall in reset", bus.Stall, 0);
    chk("rstmid PC_From_Memory", bus.PC_From_Memory, 0);
    chk("rstmid WB_Data", bus.WB_Data, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    expect_at(1, "ld19", KWb, 1, 7, 32'h1111);
    op("ld19", 1, 0, 1, 7, 0, 0, 0, 0, 19, 0);
    expect_at(1, "ld20", KWb, 1, 2, 32'hCAFE);
    op("ld20", 1, 0, 1, 2, 0, 0, 0, 0, 20, 0);

    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
